// File: rtl/pio_tx_feeder.sv
// pio_tx_feeder: buffers a byte stream in a small FIFO and feeds it to one
// PIO state machine TX FIFO as PUSH actions, throttled by that machine's full flag.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   in_data/in_valid  upstream byte and its valid
//   in_ready          local FIFO can accept a byte
//   action/din/mindex registered PIO action bus (NONE=0, PUSH=4)
//   full/empty        PIO TX FIFO flags; only full[SM] steers the FSM
//   count             bytes held in the local FIFO
//   busy              FIFO not empty or a push sequence in progress
module pio_tx_feeder #(
    parameter int DEPTH = 4,
    parameter int SM    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [3:0]               action,
    output logic [31:0]              din,
    output logic [1:0]               mindex,
    input  logic [3:0]               full,
    input  logic [3:0]               empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [3:0] ACT_NONE = 4'd0;
    localparam logic [3:0] ACT_PUSH = 4'd4;

    localparam logic [1:0]  SM_IDX    = 2'(SM);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic          wr;
    logic          pop;

    // Only full[SM] matters; the rest of full[] and all of empty[] are
    // observation-only inputs.
    logic unused_flags;
    assign unused_flags = ^{empty, full};

    assign in_ready = !reset && (count < DEPTH_C);
    assign wr       = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && (count != '0) && !full[SM];
    assign busy     = (count != '0) || (state != S_IDLE);

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            action <= ACT_NONE;
            din    <= '0;
            mindex <= SM_IDX;
        end else begin
            mindex <= SM_IDX;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        action <= ACT_PUSH;
                        din    <= {24'h0, mem[rd_ptr]};
                        state  <= S_ISSUE;
                    end else begin
                        action <= ACT_NONE;
                    end
                end
                S_ISSUE: begin
                    action <= ACT_NONE;
                    din    <= '0;
                    state  <= S_HOLD;
                end
                // Dead cycle: lets the PIO full flag reflect the push
                // before IDLE samples it again.
                S_HOLD: begin
                    action <= ACT_NONE;
                    state  <= S_IDLE;
                end
                default: begin
                    action <= ACT_NONE;
                    din    <= '0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
